// File: rtl/sram_bus_master.sv
// sram_bus_master: arbitrated SRAM read/write cycle generator with parameterised setup/strobe/hold timing.
module sram_bus_master #(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 3,
    parameter int HOLD_CYC   = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rwn,
    input  logic [20:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic [20:0] mem_addr,
    output logic        mal_oe,
    output logic [7:0]  md_out,
    output logic        md_oe,
    input  logic [7:0]  md_in,
    output logic        m1csn,
    output logic        mrdn,
    output logic        mwrn
);
    typedef enum logic [2:0] {IDLE, WAITGNT, SETUP, STROBE, HOLD, DONE} state_t;
    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);
    state_t state, nxt;
    logic [3:0] cnt, cnt_nxt;
    logic rwn, active, accept;
    assign accept = state == IDLE && req_valid && req_ready;
    always_comb begin
        nxt = state;
        cnt_nxt = cnt;
        case (state)
            IDLE:    if (accept) nxt = WAITGNT;
            WAITGNT: if (bus_gnt) begin nxt = SETUP; cnt_nxt = SETUP_LD; end
            SETUP:   if (cnt == 4'd0) begin nxt = STROBE; cnt_nxt = STROBE_LD; end else cnt_nxt = cnt - 4'd1;
            STROBE:  if (cnt == 4'd0) begin nxt = HOLD; cnt_nxt = HOLD_LD; end else cnt_nxt = cnt - 4'd1;
            HOLD:    if (cnt == 4'd0) nxt = DONE; else cnt_nxt = cnt - 4'd1;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end
    // Outputs are registered from the next state so each pin changes on the phase-entry edge.
    assign active = nxt inside {SETUP, STROBE, HOLD};
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            rwn       <= 1'b1;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'h00;
            bus_req   <= 1'b0;
            mem_addr  <= 21'd0;
            mal_oe    <= 1'b0;
            md_out    <= 8'h00;
            md_oe     <= 1'b0;
            m1csn     <= 1'b1;
            mrdn      <= 1'b1;
            mwrn      <= 1'b1;
        end else begin
            state     <= nxt;
            cnt       <= cnt_nxt;
            req_ready <= nxt == IDLE;
            rsp_valid <= nxt == DONE;
            bus_req   <= nxt == WAITGNT || active;
            mal_oe    <= active;
            m1csn     <= !active;
            md_oe     <= active && !rwn;
            mrdn      <= !(nxt == STROBE && rwn);
            mwrn      <= !(nxt == STROBE && !rwn);
            if (accept) begin
                rwn      <= req_rwn;
                mem_addr <= req_addr;
                md_out   <= req_wdata;
            end
            if (state == STROBE && cnt == 4'd0 && rwn) rsp_rdata <= md_in;
        end
    end
endmodule

// File: tb/tb_sram_bus_master.sv
// tb_sram_bus_master: randomized transactions against a transaction-level memory/timing model.
module tb_sram_bus_master;
    logic clk = 1'b0, resetn = 1'b0;
    always #5 clk = ~clk;
    logic req_valid = 1'b0, req_rwn = 1'b1, bus_gnt = 1'b1, sel = 1'b0, mon_on = 1'b0, cur_rd = 1'b1;
    logic [20:0] req_addr = '0;
    logic [7:0] req_wdata = '0, md_in = '0;
    logic rv_a, rv_b;
    logic rdy_a, rsp_a, breq_a, mal_a, mdoe_a, csn_a, rdn_a, wrn_a;
    logic rdy_b, rsp_b, breq_b, mal_b, mdoe_b, csn_b, rdn_b, wrn_b;
    logic [7:0] rdat_a, mdo_a, rdat_b, mdo_b;
    logic [20:0] addr_a, addr_b;
    logic v_rdy, v_rsp, v_breq, v_mdoe, v_csn, v_rdn, v_wrn;
    logic [7:0] v_rdat, v_mdo;
    logic [20:0] v_addr;
    int total = 0, bad = 0;
    logic [7:0] sram [int];
    logic [7:0] ref_mem [int];
    logic prev_wrn = 1'b1;

    assign rv_a = req_valid && !sel;
    assign rv_b = req_valid && sel;
    assign v_rdy  = sel ? rdy_b  : rdy_a;
    assign v_rsp  = sel ? rsp_b  : rsp_a;
    assign v_breq = sel ? breq_b : breq_a;
    assign v_mdoe = sel ? mdoe_b : mdoe_a;
    assign v_csn  = sel ? csn_b  : csn_a;
    assign v_rdn  = sel ? rdn_b  : rdn_a;
    assign v_wrn  = sel ? wrn_b  : wrn_a;
    assign v_rdat = sel ? rdat_b : rdat_a;
    assign v_mdo  = sel ? mdo_b  : mdo_a;
    assign v_addr = sel ? addr_b : addr_a;

    sram_bus_master dut_a (
        .clk(clk), .resetn(resetn), .req_valid(rv_a), .req_ready(rdy_a), .req_rwn(req_rwn),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_a), .rsp_rdata(rdat_a),
        .bus_req(breq_a), .bus_gnt(bus_gnt), .mem_addr(addr_a), .mal_oe(mal_a), .md_out(mdo_a),
        .md_oe(mdoe_a), .md_in(md_in), .m1csn(csn_a), .mrdn(rdn_a), .mwrn(wrn_a));

    sram_bus_master #(.SETUP_CYC(2), .STROBE_CYC(1), .HOLD_CYC(3)) dut_b (
        .clk(clk), .resetn(resetn), .req_valid(rv_b), .req_ready(rdy_b), .req_rwn(req_rwn),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_b), .rsp_rdata(rdat_b),
        .bus_req(breq_b), .bus_gnt(bus_gnt), .mem_addr(addr_b), .mal_oe(mal_b), .md_out(mdo_b),
        .md_oe(mdoe_b), .md_in(md_in), .m1csn(csn_b), .mrdn(rdn_b), .mwrn(wrn_b));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rd_sram(input logic [20:0] a);
        return sram.exists(int'(a)) ? sram[int'(a)] : 8'h00;
    endfunction

    function automatic logic [7:0] exp_rd(input logic [20:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 8'h00;
    endfunction

    // SRAM device: latches data on the rising write strobe, drives data while read strobe is low.
    always @(negedge clk) begin
        if (!prev_wrn && v_wrn && !v_csn && v_mdoe) sram[int'(v_addr)] = v_mdo;
        prev_wrn = v_wrn;
        md_in = (!v_csn && !v_rdn) ? rd_sram(v_addr) : 8'h5A;
    end

    always @(negedge clk) begin
        if (mon_on) begin
            chk("both_strobes_a", {31'd0, !rdn_a && !wrn_a}, 0);
            chk("strobe_no_cs_a", {31'd0, (!rdn_a || !wrn_a) && csn_a}, 0);
            chk("both_strobes_b", {31'd0, !rdn_b && !wrn_b}, 0);
            chk("strobe_no_cs_b", {31'd0, (!rdn_b || !wrn_b) && csn_b}, 0);
            chk("md_oe_on_read", {31'd0, v_mdoe && cur_rd}, 0);
        end
    end

    task automatic txn(input bit rd, input logic [20:0] a, input logic [7:0] d, input int gd,
                       input bit drop, input int s, input int t, input int h);
        int n, w, cs_n, cs_first, cs_last, st_n, st_first, st_last, wrong, br_n, oe_n, bad_addr, bad_data, lw;
        bit seen;
        logic [7:0] got;
        n = 1; cs_n = 0; cs_first = 0; cs_last = 0; st_n = 0; st_first = 0; st_last = 0;
        wrong = 0; br_n = 0; oe_n = 0; bad_addr = 0; bad_data = 0; seen = 0; got = 8'h00;
        lw = gd > 1 ? gd : 1;
        cur_rd = rd; req_rwn = rd; req_addr = a; req_wdata = d; req_valid = 1'b1; bus_gnt = gd == 0;
        w = 0;
        while (!v_rdy && w < 50) begin @(negedge clk); w++; end
        chk("accept", {31'd0, v_rdy}, 1);
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            req_valid = 1'b0;
            if (!v_csn) begin
                cs_n++; cs_last = n;
                if (cs_first == 0) cs_first = n;
                if (v_addr !== a) bad_addr++;
            end
            if (!v_rdn || !v_wrn) begin
                st_n++; st_last = n;
                if (st_first == 0) st_first = n;
                if ((rd ? v_wrn : v_rdn) == 1'b0) wrong++;
            end
            if (v_breq) br_n++;
            if (v_mdoe) begin oe_n++; if (v_mdo !== d) bad_data++; end
            if (v_rsp) begin seen = 1; got = v_rdat; end
            bus_gnt = (n > gd) && !(drop && cs_n > 0);
        end
        chk("rsp_seen", {31'd0, seen}, 1);
        chk("latency", n, 2 + lw + s + t + h);
        chk("cs_start", cs_first, 2 + lw);
        chk("cs_len", cs_n, s + t + h);
        chk("setup_len", st_first - cs_first, s);
        chk("strobe_len", st_n, t);
        chk("hold_len", cs_last - st_last, h);
        chk("bus_req_len", br_n, lw + s + t + h);
        chk("wrong_strobe", wrong, 0);
        chk("addr_held", bad_addr, 0);
        chk("md_oe_len", oe_n, rd ? 0 : s + t + h);
        chk("wdata_held", bad_data, 0);
        if (rd) chk("rdata", {24'd0, got}, {24'd0, exp_rd(a)});
        else ref_mem[int'(a)] = d;
        bus_gnt = 1'b1;
        @(negedge clk);
        chk("rsp_one_pulse", {31'd0, v_rsp}, 0);
        chk("ready_again", {31'd0, v_rdy}, 1);
    endtask

    initial begin
        logic [20:0] pool [8];
        logic [20:0] cs_q [$];
        logic [7:0] rd_q [$];
        int acc, pulses, w;
        pool = '{21'h00010, 21'h00011, 21'h1FFFFF, 21'h00000, 21'h0ABCD, 21'h10000, 21'h00FFF, 21'h01000};
        repeat (3) @(negedge clk);
        chk("rst_ctl_a", {24'd0, rdy_a, rsp_a, breq_a, mal_a, mdoe_a, csn_a, rdn_a, wrn_a}, 32'h07);
        chk("rst_data_a", {3'd0, addr_a, rdat_a}, 0);
        chk("rst_mdo_a", {24'd0, mdo_a}, 0);
        chk("rst_ctl_b", {24'd0, rdy_b, rsp_b, breq_b, mal_b, mdoe_b, csn_b, rdn_b, wrn_b}, 32'h07);
        resetn = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", {31'd0, rdy_a}, 1);
        mon_on = 1'b1;

        txn(0, 21'h00010, 8'h12, 0, 0, 1, 3, 1);
        chk("sram_store", {24'd0, rd_sram(21'h00010)}, 32'h12);
        txn(1, 21'h00010, 8'h00, 0, 0, 1, 3, 1);
        txn(1, 21'h00010, 8'h00, 20, 0, 1, 3, 1);
        txn(0, 21'h1FFFFF, 8'hA5, 0, 1, 1, 3, 1);
        txn(0, 21'h00000, 8'h3C, 2, 0, 1, 3, 1);

        cur_rd = 1'b1; req_rwn = 1'b1; req_addr = 21'h1FFFFF; req_valid = 1'b1; bus_gnt = 1'b1;
        acc = 0; pulses = 0;
        for (int i = 0; i < 30; i++) begin
            if (v_rdy && req_valid) acc++;
            @(negedge clk);
            if (acc == 1) req_addr = 21'h000000;
            if (acc == 2) req_valid = 1'b0;
            if (v_rsp) begin pulses++; rd_q.push_back(v_rdat); end
            if (!v_csn && (cs_q.size() == 0 || cs_q[$] !== v_addr)) cs_q.push_back(v_addr);
        end
        req_valid = 1'b0;
        chk("b2b_accepts", acc, 2);
        chk("b2b_pulses", pulses, 2);
        chk("b2b_addr_cnt", cs_q.size(), 2);
        if (cs_q.size() == 2) begin
            chk("b2b_addr0", {11'd0, cs_q[0]}, {11'd0, 21'h1FFFFF});
            chk("b2b_addr1", {11'd0, cs_q[1]}, 0);
        end
        if (rd_q.size() == 2) begin
            chk("b2b_rdata0", {24'd0, rd_q[0]}, {24'd0, exp_rd(21'h1FFFFF)});
            chk("b2b_rdata1", {24'd0, rd_q[1]}, {24'd0, exp_rd(21'h000000)});
        end

        for (int i = 0; i < 30; i++)
            txn(1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)], 8'($urandom), $urandom_range(0, 3),
                $urandom_range(0, 3) == 0, 1, 3, 1);

        sel = 1'b1;
        @(negedge clk);
        txn(0, 21'h00777, 8'hC3, 0, 0, 2, 1, 3);
        txn(1, 21'h00777, 8'h00, 0, 0, 2, 1, 3);
        for (int i = 0; i < 4; i++)
            txn(1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)], 8'($urandom), $urandom_range(0, 3),
                $urandom_range(0, 1) == 0, 2, 1, 3);
        sel = 1'b0;
        @(negedge clk);

        txn(0, 21'h00ABC, 8'h77, 0, 0, 1, 3, 1);
        cur_rd = 1'b0; req_rwn = 1'b0; req_addr = 21'h00ABC; req_wdata = 8'hFF; bus_gnt = 1'b1; req_valid = 1'b1;
        w = 0;
        while (!v_rdy && w < 20) begin @(negedge clk); w++; end
        @(negedge clk);
        req_valid = 1'b0;
        w = 0;
        while (v_wrn && w < 20) begin @(negedge clk); w++; end
        chk("reach_strobe", {31'd0, v_wrn}, 0);
        resetn = 1'b0;
        @(negedge clk);
        chk("abort_mwrn", {31'd0, wrn_a}, 1);
        chk("abort_csn", {31'd0, csn_a}, 1);
        chk("abort_md_oe", {31'd0, mdoe_a}, 0);
        chk("abort_bus_req", {31'd0, breq_a}, 0);
        resetn = 1'b1;
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (v_rsp) pulses++;
        end
        chk("abort_no_rsp", pulses, 0);
        chk("abort_no_write", {24'd0, rd_sram(21'h00ABC)}, {24'd0, exp_rd(21'h00ABC)});
        txn(1, 21'h00ABC, 8'h00, 0, 0, 1, 3, 1);
        txn(0, 21'h00ABC, 8'h99, 1, 0, 1, 3, 1);
        txn(1, 21'h00ABC, 8'h00, 0, 0, 1, 3, 1);

        mon_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
